disp_colr_adapt: RTL and testbench

Pixel-domain colour adapter between the display pipeline and the board serializer/encoder. Converts any number of colour channels from the system bit depth to the board bit depth. Expansion is done by MSB-first bit replication. Reduction uses truncation or ordered (Bayer 4×4, frame-rotated) dither. Sync and data-enable are delay-matched so all outputs are cycle-aligned.

---
 rtl/display_pkg.sv | 19 +
 rtl/disp_colr_adapt_if.sv | 27 ++
 rtl/disp_dither_pos.sv | 54 +++++
 rtl/disp_colr_adapt.sv | 113 +++++++++++
 tb/tb_disp_colr_adapt.sv | 139 +++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared display-pipeline constants: ordered-dither threshold table and the
// fixed pixel-path latency that downstream delay matching relies on.
package display_pkg;

  localparam int DISP_LAT = 2;

  // Entry [row*4+col]; listed high index first so BAYER4[0] is the top-left threshold.
  localparam logic [15:0][3:0] BAYER4 = {
    4'd5, 4'd13, 4'd7, 4'd15,
    4'd9, 4'd1,  4'd11, 4'd3,
    4'd6, 4'd14, 4'd4, 4'd12,
    4'd10, 4'd2, 4'd8, 4'd0
  };

  function automatic logic [3:0] bayer4_at(input logic [3:0] idx);
    return BAYER4[idx];
  endfunction

endpackage

// File: rtl/disp_colr_adapt_if.sv
// Pixel bus between the display pipeline and the colour adapter: input pixel
// stream (master drives) and the delay-matched converted stream (slave drives).
interface disp_colr_adapt_if #(
  parameter int CHANNELS = 3,
  parameter int BPC_IN   = 5,
  parameter int BPC_OUT  = 8
);
  logic                         in_de;
  logic                         in_hsync;
  logic                         in_vsync;
  logic                         in_frame;
  logic [CHANNELS*BPC_IN-1:0]   in_colr;
  logic                         out_de;
  logic                         out_hsync;
  logic                         out_vsync;
  logic [CHANNELS*BPC_OUT-1:0]  out_colr;

  modport master (
    output in_de, in_hsync, in_vsync, in_frame, in_colr,
    input  out_de, out_hsync, out_vsync, out_colr
  );

  modport slave (
    input  in_de, in_hsync, in_vsync, in_frame, in_colr,
    output out_de, out_hsync, out_vsync, out_colr
  );
endinterface

// File: rtl/disp_dither_pos.sv
// Screen-position tracker for ordered dither: 2-bit column/row/frame counters
// folded into a 4-bit Bayer table index for the pixel currently on the input.
module disp_dither_pos
  import display_pkg::*;
(
  input  logic       clk_pix,
  input  logic       rst_pix_n,
  input  logic       de_i,
  input  logic       frame_i,
  output logic [3:0] idx_o
);

  logic [1:0] x_q, x_d;
  logic [1:0] y_q, y_d;
  logic [1:0] f_q, f_d;
  logic       de_prev_q;
  logic       de_fall;

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      x_q       <= 2'd0;
      y_q       <= 2'd0;
      f_q       <= 2'd0;
      de_prev_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      f_q       <= f_d;
      de_prev_q <= de_i;
    end
  end

  assign de_fall = de_prev_q & ~de_i;

  // Frame start overrides the end-of-line row step.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    f_d = f_q;
    if (de_i) x_d = x_q + 2'd1;
    if (de_fall) begin
      x_d = 2'd0;
      y_d = y_q + 2'd1;
    end
    if (frame_i) begin
      x_d = 2'd0;
      y_d = 2'd0;
      f_d = f_q + 2'd1;
    end
  end

  assign idx_o = {y_q, x_q ^ f_q};

endmodule

// File: rtl/disp_colr_adapt.sv
// Colour depth adapter: replicate-expand or truncate/dither-reduce every channel,
// two-stage pipeline with matched syncs. Ordered dither built when DISP_DITHER_EN is defined.
module disp_colr_adapt
  import display_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int BPC_IN   = 5,
  parameter int BPC_OUT  = 8
) (
  input  logic              clk_pix,
  input  logic              rst_pix_n,
  disp_colr_adapt_if.slave  bus
);

  localparam int WI  = CHANNELS * BPC_IN;
  localparam int WO  = CHANNELS * BPC_OUT;
  localparam int SBW = 3 * DISP_LAT;

  genvar gi, gb;

  logic [SBW-1:0] sb_q, sb_d;
  logic [WI-1:0]  colr1_q;
  logic [WO-1:0]  colr2_q, colr2_d;
  logic [WO-1:0]  conv;

  // Sideband shift line {de,hsync,vsync} per stage; bits [2:0] are stage 1.
  assign sb_d = {sb_q[SBW-4:0], bus.in_de, bus.in_hsync, bus.in_vsync};

  // Blanked pixels leave as zero no matter what colour arrived.
  assign colr2_d = sb_q[2] ? conv : '0;

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      sb_q    <= '0;
      colr1_q <= '0;
      colr2_q <= '0;
    end else begin
      sb_q    <= sb_d;
      colr1_q <= bus.in_colr;
      colr2_q <= colr2_d;
    end
  end

`ifdef DISP_DITHER_EN
  logic [3:0] pos_idx;
  logic [3:0] t1_q;

  disp_dither_pos u_pos (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_pix_n),
    .de_i      (bus.in_de),
    .frame_i   (bus.in_frame),
    .idx_o     (pos_idx)
  );

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) t1_q <= 4'd0;
    else            t1_q <= bayer4_at(pos_idx);
  end
`else
  logic unused_frame;
  assign unused_frame = bus.in_frame;
`endif

  generate
    if (BPC_OUT >= BPC_IN) begin : g_expand
      // Output bit gb takes input bit counted MSB-first, wrapping every BPC_IN bits.
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
        for (gb = 0; gb < BPC_OUT; gb++) begin : g_bit
          assign conv[gi*BPC_OUT + gb] =
            colr1_q[gi*BPC_IN + BPC_IN - 1 - ((BPC_OUT - 1 - gb) % BPC_IN)];
        end
      end
`ifdef DISP_DITHER_EN
      logic unused_t;
      assign unused_t = ^t1_q;
`endif
    end else begin : g_reduce
      localparam int D = BPC_IN - BPC_OUT;
`ifdef DISP_DITHER_EN
      // Threshold aligned so its 4 bits span the D discarded LSBs.
      logic [BPC_IN:0] t_sc;
      for (gi = 0; gi <= BPC_IN; gi++) begin : g_tsc
        if ((gi + 4 - D >= 0) && (gi + 4 - D < 4)) begin : g_src
          assign t_sc[gi] = t1_q[gi + 4 - D];
        end else begin : g_zero
          assign t_sc[gi] = 1'b0;
        end
      end
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [BPC_IN:0] sum;
        logic            unused_lsb;
        assign sum = {1'b0, colr1_q[gi*BPC_IN +: BPC_IN]} + t_sc;
        assign conv[gi*BPC_OUT +: BPC_OUT] =
          sum[BPC_IN] ? {BPC_OUT{1'b1}} : sum[BPC_IN-1 -: BPC_OUT];
        assign unused_lsb = ^sum[D-1:0];
      end
`else
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic unused_lsb;
        assign conv[gi*BPC_OUT +: BPC_OUT] = colr1_q[gi*BPC_IN + BPC_IN - 1 -: BPC_OUT];
        assign unused_lsb = ^colr1_q[gi*BPC_IN +: D];
      end
`endif
    end
  endgenerate

  assign bus.out_de    = sb_q[SBW-1];
  assign bus.out_hsync = sb_q[SBW-2];
  assign bus.out_vsync = sb_q[SBW-3];
  assign bus.out_colr  = colr2_q;

endmodule

// File: tb/tb_disp_colr_adapt.sv
// Directed bench: a 5->8 expanding instance and an 8->5 reducing instance share
// clock, reset and sync stimulus; outputs are checked two cycles after each input.
module tb_disp_colr_adapt;

`ifdef DISP_DITHER_EN
  localparam bit DITH = 1'b1;
`else
  localparam bit DITH = 1'b0;
`endif

  logic clk_pix = 1'b0;
  logic rst_pix_n = 1'b0;
  always #5 clk_pix = ~clk_pix;

  disp_colr_adapt_if #(.CHANNELS(3), .BPC_IN(5), .BPC_OUT(8)) if_e ();
  disp_colr_adapt_if #(.CHANNELS(3), .BPC_IN(8), .BPC_OUT(5)) if_r ();

  disp_colr_adapt #(.CHANNELS(3), .BPC_IN(5), .BPC_OUT(8)) u_exp (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_pix_n),
    .bus       (if_e)
  );

  disp_colr_adapt #(.CHANNELS(3), .BPC_IN(8), .BPC_OUT(5)) u_red (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_pix_n),
    .bus       (if_r)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int ones    = 0;
  logic [26:0] prev_e = '0;
  logic [17:0] prev_r = '0;

  localparam logic [14:0] E_IN  = {5'h01, 5'h0A, 5'h15};
  localparam logic [23:0] E_OUT = {8'h08, 8'h52, 8'hAD};

  // One pixel clock: drive, then check outputs against the previous call's expectation.
  task automatic cyc(input string tag, input logic rst, input logic de, input logic hs,
                     input logic vs, input logic fr, input logic [14:0] ce,
                     input logic [23:0] cr, input logic [23:0] xe, input logic [14:0] xr);
    logic [26:0] obs_e;
    logic [17:0] obs_r;
    rst_pix_n     = rst;
    if_e.in_de    = de;  if_e.in_hsync = hs; if_e.in_vsync = vs;
    if_e.in_frame = fr;  if_e.in_colr  = ce;
    if_r.in_de    = de;  if_r.in_hsync = hs; if_r.in_vsync = vs;
    if_r.in_frame = fr;  if_r.in_colr  = cr;
    @(negedge clk_pix);
    if (!rst) begin
      prev_e = '0;
      prev_r = '0;
    end
    obs_e = {if_e.out_de, if_e.out_hsync, if_e.out_vsync, if_e.out_colr};
    obs_r = {if_r.out_de, if_r.out_hsync, if_r.out_vsync, if_r.out_colr};
    n_tests++;
    assert (obs_e === prev_e) else begin
      n_fail++;
      $error("FAIL %s/expand observed=%h expected=%h", tag, obs_e, prev_e);
    end
    n_tests++;
    assert (obs_r === prev_r) else begin
      n_fail++;
      $error("FAIL %s/reduce observed=%h expected=%h", tag, obs_r, prev_r);
    end
    if (if_r.out_de === 1'b1 && if_r.out_colr[14:10] === 5'h01) ones++;
    if (rst) begin
      prev_e = {de, hs, vs, (de ? xe : 24'h0)};
      prev_r = {de, hs, vs, (de ? xr : 15'h0)};
    end
  endtask

  // 4x4 block of uniform reduce-side colour; each line ends with a blanking cycle.
  task automatic block(input string tag, input logic [7:0] cval, input int inv, input int exp_ones);
    logic [4:0] v;
    int b;
    ones = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        b = ((c ^ r) & 1) ^ inv;
        if (cval == 8'hFF) v = 5'h1F;
        else               v = (DITH && b == 1) ? 5'h01 : 5'h00;
        cyc(tag, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_IN, {3{cval}}, E_OUT, {3{v}});
      end
      cyc(tag, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, E_IN, {3{cval}}, 24'h0, 15'h0);
    end
    n_tests++;
    assert (ones === exp_ones) else begin
      n_fail++;
      $error("FAIL %s/count observed=%0d expected=%0d", tag, ones, exp_ones);
    end
  endtask

  initial begin
    // Reset state
    cyc("reset0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0, 24'h0, 24'h0, 15'h0);
    cyc("reset1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 15'h7FFF, 24'hFFFFFF, 24'h0, 15'h0);
    cyc("idle",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0, 24'h0, 24'h0, 15'h0);
    cyc("idle",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0, 24'h0, 24'h0, 15'h0);

    // Uniform 8'h04 block at f=0: threshold >= 8 where col^row is odd
    block("dith_f0", 8'h04, 0, DITH ? 8 : 0);

    // Frame pulse rotates columns by one: pixel map inverts
    cyc("frame", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 15'h0, 24'h0, 24'h0, 15'h0);
    block("dith_f1", 8'h04, 1, DITH ? 8 : 0);

    // Saturation: full-scale input never wraps
    block("sat", 8'hFF, 0, 0);

    // Blanking with sync toggles and nonzero colour
    cyc("blank_01", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 15'h7FFF, 24'hFFFFFF, 24'hFFFFFF, 15'h7FFF);
    cyc("blank_10", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 15'h1234, 24'h123456, 24'hFFFFFF, 15'h7FFF);
    cyc("blank_11", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 15'h5555, 24'hAAAAAA, 24'hFFFFFF, 15'h7FFF);
    cyc("blank_00", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15'h2AAA, 24'h555555, 24'hFFFFFF, 15'h7FFF);

    // Expansion 5->8; reduce-side values chosen so any threshold leaves the top bits intact
    cyc("expand_a", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, {5'h1F, 5'h10, 5'h00}, {8'h80, 8'hF8, 8'h00},
        {8'hFF, 8'h84, 8'h00}, {5'h10, 5'h1F, 5'h00});
    cyc("expand_b", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, {5'h15, 5'h0A, 5'h01}, {8'h08, 8'h10, 8'hF0},
        {8'hAD, 8'h52, 8'h08}, {5'h01, 5'h02, 5'h1E});

    // Reset mid-line: outputs clear at once, first pixel 2 cycles after release, dither from index 0
    cyc("rst_mid", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 15'h7FFF, 24'hFFFFFF, 24'hFFFFFF, 15'h7FFF);
    cyc("post_rst0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_IN, {3{8'h04}}, E_OUT, {3{5'h00}});
    cyc("post_rst1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_IN, {3{8'h04}}, E_OUT,
        DITH ? {3{5'h01}} : 15'h0);
    cyc("post_rst2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_IN, {3{8'h04}}, E_OUT, {3{5'h00}});
    cyc("post_rst3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_IN, {3{8'h04}}, E_OUT,
        DITH ? {3{5'h01}} : 15'h0);
    cyc("flush", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0, 24'h0, 24'h0, 15'h0);
    cyc("flush", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0, 24'h0, 24'h0, 15'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
